// File: rtl/cot_pkg.sv
// Shared encodings and helpers for the constant-on-time phase scheduler.
package cot_pkg;

  typedef enum logic [1:0] {
    TOP_IDLE  = 2'd0,
    TOP_RUN   = 2'd1,
    TOP_FAULT = 2'd2
  } top_state_t;

  typedef enum logic [1:0] {
    PH_OFF     = 2'd0,
    PH_ON      = 2'd1,
    PH_MIN_OFF = 2'd2
  } phase_state_t;

  // Bits needed to hold values 0..n-1; at least 1 so single-value fields stay legal.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/cot_phase_timer.sv
// One phase of the scheduler: fixed on-time pulse followed by a minimum off-time.
module cot_phase_timer
  import cot_pkg::*;
#(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] ton_cycles,
  input  logic [CNT_W-1:0] toff_min,
  output logic             pwm,
  output logic             ready
);

  phase_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] lim, lim_n;

  // One counter serves both intervals; lim holds whichever compare value is live.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n = state;
    cnt_n   = cnt;
    lim_n   = lim;
    unique case (state)
      PH_OFF: begin
        if (start) begin
          state_n = PH_ON;
          cnt_n   = CNT_W'(1);
          lim_n   = (ton_cycles == '0) ? CNT_W'(1) : ton_cycles;
        end
      end
      PH_ON: begin
        if (cnt == lim) begin
          state_n = (toff_min == '0) ? PH_OFF : PH_MIN_OFF;
          cnt_n   = CNT_W'(1);
          lim_n   = toff_min;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PH_MIN_OFF: begin
        if (cnt == lim) state_n = PH_OFF;
        else            cnt_n   = cnt + CNT_W'(1);
      end
      default: state_n = PH_OFF;
    endcase
    if (abort) state_n = PH_OFF;
  end

  // NOTE: state uses non-blocking assignments and an async clear so pwm drops the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PH_OFF;
      cnt   <= '0;
      lim   <= '0;
      pwm   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lim   <= lim_n;
      pwm   <= (state_n == PH_ON);
    end
  end

  assign ready = (state == PH_OFF);

endmodule

// File: rtl/cot_phase_scheduler.sv
// Multi-phase constant-on-time PWM scheduler: comparator edges become fixed on-time
// pulses dealt round-robin across phases, with blanking, min off-time and fault latch.
module cot_phase_scheduler
  import cot_pkg::*;
#(
  parameter  int N_PH   = 2,
  parameter  int CNT_W  = 21,
  parameter  int TBLANK = 8,
  localparam int PTR_W  = clog2(N_PH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             trig,
  input  logic [CNT_W-1:0] ton_cycles,
  input  logic [CNT_W-1:0] toff_min,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic [N_PH-1:0]  pwm_out,
  output logic [PTR_W-1:0] phase_idx,
  output logic             busy,
  output logic             missed_trig,
  output logic             fault_latched
);

  localparam int BLANK_W = clog2(TBLANK + 2);

  top_state_t         state, state_n;
  logic               trig_dly;
  logic               trig_pos;
  logic               abort;
  logic               accept;
  logic               fire;
  logic [PTR_W-1:0]   ptr;
  logic [BLANK_W-1:0] blank;
  logic [N_PH-1:0]    start;
  logic [N_PH-1:0]    ready;
  logic [N_PH-1:0]    pwm;

  always_comb begin
    state_n = state;
    unique case (state)
      TOP_IDLE:  if (en) state_n = TOP_RUN;
      TOP_RUN: begin
        if (fault_in) state_n = TOP_FAULT;
        else if (!en) state_n = TOP_IDLE;
      end
      TOP_FAULT: if (fault_clr && !fault_in) state_n = TOP_IDLE;
      default:   state_n = TOP_IDLE;
    endcase
  end

  // Timers run only while RUN persists across the edge; any exit aborts them immediately.
  assign abort    = (state != TOP_RUN) || (state_n != TOP_RUN);
  assign trig_pos = trig && !trig_dly;
  assign accept   = !abort && trig_pos && (blank == '0);
  assign fire     = accept && ready[ptr];

  always_comb begin
    start      = '0;
    start[ptr] = fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= TOP_IDLE;
      trig_dly    <= 1'b0;
      ptr         <= '0;
      blank       <= '0;
      missed_trig <= 1'b0;
    end else begin
      state       <= state_n;
      trig_dly    <= trig;
      missed_trig <= accept && !ready[ptr];
      if (state == TOP_IDLE)
        ptr <= '0;
      else if (fire)
        ptr <= (ptr == PTR_W'(N_PH - 1)) ? '0 : ptr + PTR_W'(1);
      if (state != TOP_RUN) blank <= '0;
      else if (fire)        blank <= BLANK_W'(TBLANK);
      else if (blank != '0) blank <= blank - BLANK_W'(1);
    end
  end

  for (genvar p = 0; p < N_PH; p++) begin : g_phase
    cot_phase_timer #(
      .CNT_W(CNT_W)
    ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[p]),
      .abort     (abort),
      .ton_cycles(ton_cycles),
      .toff_min  (toff_min),
      .pwm       (pwm[p]),
      .ready     (ready[p])
    );
  end

  assign pwm_out       = pwm;
  assign phase_idx     = ptr;
  assign busy          = |(~ready);
  assign fault_latched = (state == TOP_FAULT);

endmodule

// File: tb/tb_cot_phase_scheduler.sv
// Self-checking bench: directed scenarios plus random stimulus against a cycle-window reference model.
module tb_cot_phase_scheduler;

  localparam int N_PH   = 2;
  localparam int CNT_W  = 21;
  localparam int TBLANK = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             trig = 1'b0;
  logic [CNT_W-1:0] ton_cycles = CNT_W'(40);
  logic [CNT_W-1:0] toff_min = CNT_W'(10);
  logic             fault_in = 1'b0;
  logic             fault_clr = 1'b0;
  logic [N_PH-1:0]  pwm_out;
  logic [0:0]       phase_idx;
  logic             busy;
  logic             missed_trig;
  logic             fault_latched;

  cot_phase_scheduler #(
    .N_PH  (N_PH),
    .CNT_W (CNT_W),
    .TBLANK(TBLANK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .trig         (trig),
    .ton_cycles   (ton_cycles),
    .toff_min     (toff_min),
    .fault_in     (fault_in),
    .fault_clr    (fault_clr),
    .pwm_out      (pwm_out),
    .phase_idx    (phase_idx),
    .busy         (busy),
    .missed_trig  (missed_trig),
    .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: each phase is a window of cycles [on_from, on_to] driving pwm
  // and a last busy cycle busy_to; the scheduler is tracked as plain integers.
  typedef enum {M_IDLE, M_RUN, M_FAULT} mmode_t;
  mmode_t m_mode;
  int     m_ptr;
  int     m_blank;
  bit     m_trig_dly;
  bit     m_missed;
  longint m_on_from[N_PH];
  longint m_on_to[N_PH];
  longint m_busy_to[N_PH];

  function automatic void model_reset();
    m_mode     = M_IDLE;
    m_ptr      = 0;
    m_blank    = 0;
    m_trig_dly = 1'b0;
    m_missed   = 1'b0;
    for (int p = 0; p < N_PH; p++) begin
      m_on_from[p] = 0;
      m_on_to[p]   = -1;
      m_busy_to[p] = -1;
    end
  endfunction

  task automatic model_compare();
    logic [N_PH-1:0] e_pwm;
    bit              e_busy;
    e_pwm  = '0;
    e_busy = 1'b0;
    for (int p = 0; p < N_PH; p++) begin
      e_pwm[p] = (cyc >= m_on_from[p]) && (cyc <= m_on_to[p]);
      if (cyc <= m_busy_to[p]) e_busy = 1'b1;
    end
    check("pwm_out", pwm_out, e_pwm);
    check("busy", busy, e_busy);
    check("phase_idx", phase_idx, m_ptr);
    check("missed_trig", missed_trig, m_missed);
    check("fault_latched", fault_latched, m_mode == M_FAULT);
  endtask

  function automatic void model_update(input longint c);
    bit     tp;
    bit     stay_run;
    bit     fired;
    longint t;
    tp       = trig && !m_trig_dly;
    stay_run = (m_mode == M_RUN) && !fault_in && en;
    fired    = 1'b0;
    for (int p = 0; p < N_PH; p++) begin
      if (c <= m_busy_to[p]) begin
        if (!stay_run) begin
          m_busy_to[p] = c;
          if (m_on_to[p] > c) m_on_to[p] = c;
        end else if (c == m_on_to[p]) begin
          m_busy_to[p] = c + longint'(toff_min);
        end
      end
    end
    m_missed = 1'b0;
    if (stay_run && tp && m_blank == 0) begin
      if (c > m_busy_to[m_ptr]) begin
        t = (ton_cycles == 0) ? 1 : longint'(ton_cycles);
        m_on_from[m_ptr] = c + 1;
        m_on_to[m_ptr]   = c + t;
        m_busy_to[m_ptr] = c + t;
        fired = 1'b1;
      end else begin
        m_missed = 1'b1;
      end
    end
    if (m_mode != M_RUN) m_blank = 0;
    else if (fired)      m_blank = TBLANK;
    else if (m_blank > 0) m_blank--;
    if (m_mode == M_IDLE) m_ptr = 0;
    else if (fired)       m_ptr = (m_ptr + 1) % N_PH;
    case (m_mode)
      M_IDLE:  if (en) m_mode = M_RUN;
      M_RUN:   if (fault_in) m_mode = M_FAULT; else if (!en) m_mode = M_IDLE;
      M_FAULT: if (fault_clr && !fault_in) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    m_trig_dly = trig;
  endfunction

  // Inputs for cycle cyc are already applied; compare mid-cycle, advance model, move to next cycle.
  task automatic step();
    @(negedge clk);
    model_compare();
    model_update(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    en         = 1'b0;
    trig       = 1'b0;
    fault_in   = 1'b0;
    fault_clr  = 1'b0;
    ton_cycles = CNT_W'(40);
    toff_min   = CNT_W'(10);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    check("rst_pwm", pwm_out, 0);
    check("rst_idx", phase_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_missed", missed_trig, 0);
    check("rst_fault", fault_latched, 0);
  endtask

  initial begin
    // Single pulse timing
    do_reset();
    en = 1'b1;
    run_to(100);
    trig = 1'b1;
    step();
    check("s1_pwm0_start", pwm_out[0], 1);
    check("s1_idx_adv", phase_idx, 1);
    step();
    trig = 1'b0;
    run_to(140);
    check("s1_pwm0_last", pwm_out[0], 1);
    step();
    check("s1_pwm0_end", pwm_out[0], 0);
    check("s1_busy_minoff", busy, 1);
    run_to(150);
    check("s1_busy_last", busy, 1);
    step();
    check("s1_busy_low", busy, 0);

    // Blanking, second phase, missed trigger
    do_reset();
    en = 1'b1;
    run_to(100); trig = 1'b1; step(); step(); trig = 1'b0;
    run_to(104); trig = 1'b1; step(); step(); trig = 1'b0;
    check("s2_blank_no_missed", missed_trig, 0);
    check("s2_blank_idx", phase_idx, 1);
    run_to(120); trig = 1'b1; step();
    check("s2_both_on", pwm_out, 2'b11);
    step(); trig = 1'b0;
    run_to(145); trig = 1'b1; step();
    check("s3_missed", missed_trig, 1);
    check("s3_idx_hold", phase_idx, 0);
    step(); trig = 1'b0;
    check("s3_missed_pulse", missed_trig, 0);
    run_to(160); trig = 1'b1; step();
    check("s3_refire", pwm_out, 2'b01);
    step(); trig = 1'b0;

    // Fault during a pulse
    do_reset();
    en = 1'b1;
    run_to(100); trig = 1'b1; step(); step(); trig = 1'b0;
    run_to(110); fault_in = 1'b1; step();
    check("s4_pwm_abort", pwm_out, 0);
    check("s4_latched", fault_latched, 1);
    run_to(115); trig = 1'b1; step(); step(); trig = 1'b0;
    check("s4_trig_ignored", pwm_out, 0);
    run_to(120); fault_in = 1'b0;
    run_to(125); fault_clr = 1'b1; step();
    fault_clr = 1'b0;
    check("s4_cleared", fault_latched, 0);
    run_to(130); trig = 1'b1; step();
    check("s4_rerun", pwm_out, 2'b01);
    step(); trig = 1'b0;

    // Zero on-time and mid-pulse on-time change
    do_reset();
    en = 1'b1;
    ton_cycles = '0;
    run_to(100); trig = 1'b1; step();
    check("s5_min_pulse", pwm_out[0], 1);
    step(); trig = 1'b0;
    check("s5_min_pulse_end", pwm_out[0], 0);
    ton_cycles = CNT_W'(40);
    run_to(120); trig = 1'b1; step(); step(); trig = 1'b0;
    run_to(125); ton_cycles = CNT_W'(5);
    run_to(160);
    check("s5_len_kept", pwm_out[1], 1);
    step();
    check("s5_len_end", pwm_out[1], 0);

    // Asynchronous reset mid-pulse
    do_reset();
    en = 1'b1;
    run_to(100); trig = 1'b1; step(); step(); trig = 1'b0;
    run_to(120);
    check("s6_pre_pwm", pwm_out[0], 1);
    #1 rst_n = 1'b0;
    #1;
    check("s6_async_pwm", pwm_out, 0);
    check("s6_async_busy", busy, 0);
    check("s6_async_idx", phase_idx, 0);
    do_reset();
    check("s6_ptr_after", phase_idx, 0);

    // Randomized traffic
    do_reset();
    en = 1'b1;
    ton_cycles = CNT_W'(6);
    toff_min   = CNT_W'(3);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 15) trig = ~trig;
      en = ($urandom_range(0, 199) != 0);
      if (!fault_in && $urandom_range(0, 299) == 0) fault_in = 1'b1;
      else if (fault_in && $urandom_range(0, 9) == 0) fault_in = 1'b0;
      fault_clr = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) ton_cycles = CNT_W'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0) toff_min = CNT_W'($urandom_range(0, 6));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
